// File: rtl/rs232_rx_core.sv
// ---------------------------------------------------------------------------
// rs232_rx_core
//
// RS232 receiver, 8N1, LSB first. The line is oversampled 16x per bit and
// each bit is decided by a 3-sample majority vote taken around mid-bit.
// Each received byte is presented as a one-cycle data_valid strobe; a low
// stop bit gives a one-cycle frame_err strobe instead.
//
// Ports
//   clk         in   1  system clock, single clock domain
//   rst         in   1  synchronous, active-high reset
//   rx          in   1  asynchronous serial input, idle high
//   data        out  8  last correctly received byte, held until the next one
//   data_valid  out  1  one-cycle pulse when data is updated
//   frame_err   out  1  one-cycle pulse when the stop bit is sampled low
//   busy        out  1  high whenever the receiver is not idle
// ---------------------------------------------------------------------------
module rs232_rx_core #(
    parameter int FREQ     = 50_000_000,
    parameter int BAUDRATE = 115_200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] data,
    output logic       data_valid,
    output logic       frame_err,
    output logic       busy
);

    localparam int TICK_DIV = FREQ / (BAUDRATE * 16);
    localparam int TW       = $clog2(TICK_DIV);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    state_t      r_state;
    state_t      w_next;

    logic        r_rx_meta;
    logic        r_rx_s;
    logic        r_rx_d;
    logic [1:0]  r_sync_vld;
    logic        r_armed;

    logic [TW-1:0] r_tick_cnt;
    logic [3:0]  r_samp_cnt;
    logic        r_s7;
    logic        r_s8;
    logic [2:0]  r_bit_cnt;
    logic [7:0]  r_shreg;
    logic [7:0]  r_data;
    logic        r_data_valid;
    logic        r_frame_err;

    logic        w_tick;
    logic        w_start;
    logic        w_maj;
    logic        w_decide;
    logic        w_wrap;
    logic        w_shift;
    logic        w_clr_bit;
    logic        w_inc_bit;
    logic        w_load;
    logic        w_ferr;

    // Synchronizer plus edge-detect flop. The sync flops come out of reset
    // high, so their content is not a real line sample until two clocks
    // later; r_armed only opens start detection once a genuine high has
    // been seen, so a line held low across reset never counts as an edge.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of the others, as real registers do.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_meta  <= 1'b1;
            r_rx_s     <= 1'b1;
            r_rx_d     <= 1'b1;
            r_sync_vld <= 2'b00;
            r_armed    <= 1'b0;
        end else begin
            r_rx_meta  <= rx;
            r_rx_s     <= r_rx_meta;
            r_rx_d     <= r_rx_s;
            r_sync_vld <= {r_sync_vld[0], 1'b1};
            if (r_sync_vld[1] && r_rx_s)
                r_armed <= 1'b1;
        end
    end

    assign w_start = (r_state == S_IDLE) && r_armed && r_rx_d && !r_rx_s;

    // Oversample tick generator, realigned to the start edge.
    assign w_tick = (r_tick_cnt == TW'(TICK_DIV - 1));

    always_ff @(posedge clk) begin
        if (rst || w_start) begin
            r_tick_cnt <= '0;
            r_samp_cnt <= 4'd0;
        end else if (w_tick) begin
            r_tick_cnt <= '0;
            r_samp_cnt <= r_samp_cnt + 4'd1;
        end else begin
            r_tick_cnt <= r_tick_cnt + TW'(1);
        end
    end

    // Captures at samples 7 and 8; sample 9 is the live rx_s at the decision.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s7 <= 1'b1;
            r_s8 <= 1'b1;
        end else if (w_tick) begin
            if (r_samp_cnt == 4'd7) r_s7 <= r_rx_s;
            if (r_samp_cnt == 4'd8) r_s8 <= r_rx_s;
        end
    end

    assign w_maj    = (r_s7 & r_s8) | (r_s7 & r_rx_s) | (r_s8 & r_rx_s);
    assign w_decide = w_tick && (r_samp_cnt == 4'd9);
    assign w_wrap   = w_tick && (r_samp_cnt == 4'd15);

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    // NOTE: every signal written here gets a default first, so no path
    // leaves one unassigned and no latch is inferred.
    always_comb begin
        w_next    = r_state;
        w_shift   = 1'b0;
        w_clr_bit = 1'b0;
        w_inc_bit = 1'b0;
        w_load    = 1'b0;
        w_ferr    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_start) w_next = S_START;
            end
            S_START: begin
                if (w_decide && w_maj) begin
                    w_next = S_IDLE;            // glitch, not a start bit
                end else if (w_wrap) begin
                    w_next    = S_DATA;
                    w_clr_bit = 1'b1;
                end
            end
            S_DATA: begin
                if (w_decide) w_shift = 1'b1;
                if (w_wrap) begin
                    if (r_bit_cnt == 3'd7) w_next = S_STOP;
                    else                   w_inc_bit = 1'b1;
                end
            end
            S_STOP: begin
                // Leave at mid stop bit so the next start edge is never missed.
                if (w_decide) begin
                    if (w_maj) begin
                        w_load = 1'b1;
                        w_next = S_IDLE;
                    end else begin
                        w_ferr = 1'b1;
                        w_next = S_BREAK;
                    end
                end
            end
            S_BREAK: begin
                if (r_rx_s) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_bit_cnt    <= 3'd0;
            r_shreg      <= 8'h00;
            r_data       <= 8'h00;
            r_data_valid <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            if (w_clr_bit)      r_bit_cnt <= 3'd0;
            else if (w_inc_bit) r_bit_cnt <= r_bit_cnt + 3'd1;
            if (w_shift)        r_shreg   <= {w_maj, r_shreg[7:1]};
            if (w_load)         r_data    <= r_shreg;
            r_data_valid <= w_load;
            r_frame_err  <= w_ferr;
        end
    end

    assign data       = r_data;
    assign data_valid = r_data_valid;
    assign frame_err  = r_frame_err;
    assign busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_rs232_rx_core.sv
// ---------------------------------------------------------------------------
// tb_rs232_rx_core
//
// Directed bench for rs232_rx_core at 50 MHz / 115200 baud. A behavioural
// transmitter drives rx; each frame it sends pushes the expected outcome
// (byte or framing error) to a scoreboard queue, and a monitor pops and
// compares whenever the receiver strobes data_valid or frame_err.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_rs232_rx_core;

    localparam real CLK_NS = 20.0;
    localparam real BIT_NS = 1.0e9 / 115200.0;

    typedef struct {
        logic       err;
        logic [7:0] data;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx;
    logic [7:0] data;
    logic       data_valid;
    logic       frame_err;
    logic       busy;

    exp_t       sb[$];
    logic [7:0] last_good = 8'h00;
    logic [1:0] prev_pulse = 2'b00;
    int         checks = 0;
    int         errors = 0;

    rs232_rx_core #(
        .FREQ    (50_000_000),
        .BAUDRATE(115_200)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .data      (data),
        .data_valid(data_valid),
        .frame_err (frame_err),
        .busy      (busy)
    );

    always #(CLK_NS / 2.0) clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One frame from the behavioural transmitter. A low stop bit leaves the
    // line low afterwards so the caller decides how long the break lasts.
    task automatic send_byte(input logic [7:0] b, input real bit_ns, input logic stop_val);
        exp_t e;
        e.err  = !stop_val;
        e.data = stop_val ? b : 8'h00;
        sb.push_back(e);
        rx = 1'b0;
        #(bit_ns);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            #(bit_ns);
        end
        rx = stop_val;
        #(bit_ns);
    endtask

    task automatic wait_drain(input string tag);
        for (int i = 0; i < 6000 && sb.size() != 0; i++) @(negedge clk);
        check({tag, "_drain"}, sb.size(), 0);
    endtask

    // Monitor: every strobe must match the head of the scoreboard.
    always @(negedge clk) begin
        logic [1:0] pulse;
        exp_t       e;
        pulse = {data_valid, frame_err};
        if (pulse != 2'b00) begin
            check("one_clk_pulse", pulse & prev_pulse, 2'b00);
            if (sb.size() == 0) begin
                check("unexpected_pulse", pulse, 2'b00);
            end else begin
                e = sb.pop_front();
                check("pulse_kind", pulse, e.err ? 2'b01 : 2'b10);
                check("pulse_data", data, e.err ? last_good : e.data);
                if (!e.err) last_good = e.data;
            end
        end
        prev_pulse = pulse;
    end

    initial begin
        #(3.0e6);
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        rx  = 1'b1;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        check("rst_data", data, 8'h00);
        check("rst_valid", data_valid, 1'b0);
        check("rst_ferr", frame_err, 1'b0);
        check("rst_busy", busy, 1'b0);
        #(BIT_NS);

        // 1: single byte
        send_byte(8'h55, BIT_NS, 1'b1);
        wait_drain("t1");
        repeat (5) @(negedge clk);
        check("t1_busy", busy, 1'b0);

        // 2: back-to-back frames
        send_byte(8'h00, BIT_NS, 1'b1);
        send_byte(8'hFF, BIT_NS, 1'b1);
        send_byte(8'hA5, BIT_NS, 1'b1);
        wait_drain("t2");
        check("t2_data", data, 8'hA5);

        // 3: 2 us glitch is a false start
        #(BIT_NS);
        @(negedge clk);
        rx = 1'b0;
        repeat (100) @(negedge clk);
        check("t3_busy_start", busy, 1'b1);
        rx = 1'b1;
        for (int i = 0; i < 330 && busy; i++) @(negedge clk);
        check("t3_busy_end", busy, 1'b0);
        #(BIT_NS);

        // 4: framing error, break held, then recovery
        send_byte(8'h3C, BIT_NS, 1'b0);
        #(20.0 * BIT_NS);
        check("t4_busy_break", busy, 1'b1);
        rx = 1'b1;
        wait_drain("t4_err");
        check("t4_data_held", data, 8'hA5);
        #(BIT_NS);
        check("t4_busy_idle", busy, 1'b0);
        send_byte(8'h81, BIT_NS, 1'b1);
        wait_drain("t4");

        // 5: baud tolerance
        #(BIT_NS);
        send_byte(8'hC3, BIT_NS / 1.03, 1'b1);
        wait_drain("t5_fast");
        #(BIT_NS);
        send_byte(8'hC3, BIT_NS / 0.97, 1'b1);
        wait_drain("t5_slow");
        check("t5_data", data, 8'hC3);

        // 6: reset in the middle of data bit 4 of 0x5A; the transmitter is
        // abandoned with the line at idle, then 0x12 follows.
        #(BIT_NS);
        rx = 1'b0;
        #(BIT_NS);
        for (int i = 0; i < 4; i++) begin
            rx = (8'h5A >> i) & 8'h01;
            #(BIT_NS);
        end
        rx = 1'b1;
        #(BIT_NS / 2.0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        last_good = 8'h00;
        check("t6_rst_busy", busy, 1'b0);
        check("t6_rst_data", data, 8'h00);
        #(2.0 * BIT_NS);
        send_byte(8'h12, BIT_NS, 1'b1);
        wait_drain("t6");
        check("t6_data", data, 8'h12);

        repeat (10) @(negedge clk);
        check("final_busy", busy, 1'b0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
